// File: rtl/dec64b66b_pkg.sv
// Shared definitions for the 64b/66b receive decoder with block lock.
//   SH_DATA / SH_CTRL : legal sync-header encodings
//   lock_state_e      : block-lock FSM states
//   TAP_A / TAP_B     : descrambler taps for x^58 + x^39 + 1
//   descramble()      : 64-bit self-synchronous descramble step, returns data and new state
package dec64b66b_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    SLIP   = 2'd2
  } lock_state_e;

  localparam int unsigned TAP_A = 38;
  localparam int unsigned TAP_B = 57;

  typedef struct packed {
    logic [63:0] data;
    logic [57:0] state;
  } descr_t;

  // Bit 0 is the first bit on the wire; the state shifts in received (scrambled) bits.
  function automatic descr_t descramble(input logic [63:0] din, input logic [57:0] state);
    descr_t      res;
    logic [57:0] s;
    s        = state;
    res.data = '0;
    for (int i = 0; i < 64; i++) begin
      res.data[i] = din[i] ^ s[TAP_A] ^ s[TAP_B];
      s           = {s[56:0], din[i]};
    end
    res.state = s;
    return res;
  endfunction

  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/descrambler58.sv
// Self-synchronous x^58 + x^39 + 1 descrambler.
//   clk, reset : clock, asynchronous active-high reset (state -> 0)
//   i_en       : advance the state with the current block
//   i_data     : 64 scrambled payload bits
//   o_data     : descrambled payload, combinational from i_data and the current state
module descrambler58
  import dec64b66b_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [63:0] i_data,
  output logic [63:0] o_data
);

  logic [57:0] r_state;
  descr_t      w_res;

  always_comb begin
    w_res = descramble(i_data, r_state);
  end

  assign o_data = w_res.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= '0;
    end else if (i_en) begin
      r_state <= w_res.state;
    end
  end

endmodule

// File: rtl/decoder64b66b_lock.sv
// 64b/66b receive decoder with block lock, bit-slip request, optional descrambler and a
// saturating sync-header error counter.
//   clk, reset           : clock, asynchronous active-high reset
//   s_axis_*             : 66-bit blocks from the RX gearbox ([1:0] sync header)
//   m_axis_*             : 2-bit raw header type plus 64-bit payload towards the PCS
//   block_lock           : high while locked
//   slip                 : one-cycle request for a 1-bit gearbox slip
//   sh_err_cnt           : invalid headers seen while locked, saturating
module decoder64b66b_lock
  import dec64b66b_pkg::*;
#(
  parameter int unsigned DESCRAMBLE  = 1,
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned INVALID_MAX = 16,
  parameter int unsigned SLIP_WAIT   = 32,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [65:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [1:0]       m_axis_ttype,
  output logic [63:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             block_lock,
  output logic             slip,
  output logic [ERR_W-1:0] sh_err_cnt
);

  localparam int unsigned CNT_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_W-1:0]  LOCK_CNT_V  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  INV_MAX_V   = CNT_W'(INVALID_MAX);
  localparam logic [WAIT_W-1:0] SLIP_WAIT_V = WAIT_W'(SLIP_WAIT);

  lock_state_e       r_state, w_state_nx;
  logic [CNT_W-1:0]  r_sh_cnt, w_sh_cnt_nx, w_cnt_inc;
  logic [CNT_W-1:0]  r_sh_inv, w_sh_inv_nx, w_inv_inc;
  logic [WAIT_W-1:0] r_wait, w_wait_nx;
  logic [ERR_W-1:0]  r_err;
  logic              r_m_valid;
  logic [1:0]        r_m_type;
  logic [63:0]       r_m_data;

  logic              w_accept;
  logic              w_sh_valid;
  logic              w_locked;
  logic [63:0]       w_payload;

  assign s_axis_tready = !r_m_valid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_sh_valid    = sh_valid(s_axis_tdata[1:0]);
  assign w_locked      = (r_state == LOCKED);

  // The descrambler sees every accepted block so it is already in sync when lock is reached.
  generate
    if (DESCRAMBLE != 0) begin : g_descr
      descrambler58 u_descr (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_accept),
        .i_data (s_axis_tdata[65:2]),
        .o_data (w_payload)
      );
    end else begin : g_bypass
      assign w_payload = s_axis_tdata[65:2];
    end
  endgenerate

  always_comb begin
    w_state_nx  = r_state;
    w_sh_cnt_nx = r_sh_cnt;
    w_sh_inv_nx = r_sh_inv;
    w_wait_nx   = r_wait;
    w_cnt_inc   = r_sh_cnt + CNT_W'(1);
    w_inv_inc   = r_sh_inv + CNT_W'(!w_sh_valid);
    unique case (r_state)
      HUNT: begin
        if (w_accept) begin
          if (!w_sh_valid) begin
            w_state_nx  = SLIP;
            w_wait_nx   = '0;
            w_sh_cnt_nx = '0;
            w_sh_inv_nx = '0;
          end else if (w_cnt_inc == LOCK_CNT_V) begin
            w_state_nx  = LOCKED;
            w_sh_cnt_nx = '0;
            w_sh_inv_nx = '0;
          end else begin
            w_sh_cnt_nx = w_cnt_inc;
          end
        end
      end
      LOCKED: begin
        if (w_accept) begin
          // Loss of lock is checked first so it wins over a window wrap on the same block.
          if (w_inv_inc == INV_MAX_V) begin
            w_state_nx  = SLIP;
            w_wait_nx   = '0;
            w_sh_cnt_nx = '0;
            w_sh_inv_nx = '0;
          end else if (w_cnt_inc == LOCK_CNT_V) begin
            w_sh_cnt_nx = '0;
            w_sh_inv_nx = '0;
          end else begin
            w_sh_cnt_nx = w_cnt_inc;
            w_sh_inv_nx = w_inv_inc;
          end
        end
      end
      SLIP: begin
        // Cycle 0 carries the slip pulse, then SLIP_WAIT further clocks before hunting.
        if (r_wait == SLIP_WAIT_V) begin
          w_state_nx  = HUNT;
          w_wait_nx   = '0;
          w_sh_cnt_nx = '0;
          w_sh_inv_nx = '0;
        end else begin
          w_wait_nx = r_wait + WAIT_W'(1);
        end
      end
      default: begin
        w_state_nx = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= HUNT;
      r_sh_cnt <= '0;
      r_sh_inv <= '0;
      r_wait   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_sh_cnt <= w_sh_cnt_nx;
      r_sh_inv <= w_sh_inv_nx;
      r_wait   <= w_wait_nx;
    end
  end

  // Single output register; a beat loaded before lock loss is still delivered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m_type  <= '0;
      r_m_data  <= '0;
    end else if (w_accept && w_locked) begin
      r_m_valid <= 1'b1;
      r_m_type  <= s_axis_tdata[1:0];
      r_m_data  <= w_payload;
    end else if (m_axis_tready) begin
      r_m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= '0;
    end else if (w_accept && w_locked && !w_sh_valid && (r_err != {ERR_W{1'b1}})) begin
      r_err <= r_err + ERR_W'(1);
    end
  end

  assign m_axis_tvalid = r_m_valid;
  assign m_axis_ttype  = r_m_type;
  assign m_axis_tdata  = r_m_data;
  assign block_lock    = w_locked;
  assign slip          = (r_state == SLIP) && (r_wait == '0);
  assign sh_err_cnt    = r_err;

endmodule

// File: tb/tb_decoder64b66b_lock.sv
// Bench for decoder64b66b_lock: a scrambling transmitter, a block-level lock model and
// per-cycle comparisons. A second instance with ERR_W=4 sees the same stream to show
// error-counter saturation.
module tb_decoder64b66b_lock;

  localparam int LOCK_CNT    = 64;
  localparam int INVALID_MAX = 16;
  localparam int SLIP_WAIT   = 32;
  localparam int P_HUNT      = 0;
  localparam int P_LOCK      = 1;
  localparam int P_SLIP      = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [65:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        m_axis_tready = 1'b1;

  logic        s_rdy, m_vld, lock, slp;
  logic [1:0]  m_typ;
  logic [63:0] m_dat;
  logic [15:0] err_cnt;

  logic        e4_s_rdy, e4_m_vld, e4_lock, e4_slp;
  logic [1:0]  e4_m_typ;
  logic [63:0] e4_m_dat;
  logic [3:0]  e4_err;

  decoder64b66b_lock dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_rdy),
    .m_axis_ttype  (m_typ),
    .m_axis_tdata  (m_dat),
    .m_axis_tvalid (m_vld),
    .m_axis_tready (m_axis_tready),
    .block_lock    (lock),
    .slip          (slp),
    .sh_err_cnt    (err_cnt)
  );

  decoder64b66b_lock #(.ERR_W(4)) dut_e4 (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (e4_s_rdy),
    .m_axis_ttype  (e4_m_typ),
    .m_axis_tdata  (e4_m_dat),
    .m_axis_tvalid (e4_m_vld),
    .m_axis_tready (m_axis_tready),
    .block_lock    (e4_lock),
    .slip          (e4_slp),
    .sh_err_cnt    (e4_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state, per block and per clock.
  int          ph, good, win, bad, err;
  longint      cyc, slip_start;
  logic        ex_v;
  logic [1:0]  ex_t;
  logic [63:0] ex_d;

  // Transmitter: scrambler seeded with ones, held block, header plan.
  logic [57:0] tx_s = 58'h3FF_FFFF_FFFF_FFFF;
  logic [63:0] cur_plain;
  logic [1:0]  hq[$];
  int          valid_pct, rdy_mode, bad_pct, slip_seen;
  logic        last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph         = P_HUNT;
    good       = 0;
    win        = 0;
    bad        = 0;
    err        = 0;
    slip_start = -1;
    ex_v       = 1'b0;
    ex_t       = '0;
    ex_d       = '0;
    last_acc   = 1'b0;
  endtask

  task automatic gen_block();
    logic [1:0]  h;
    logic [63:0] sc;
    if (ph != P_SLIP && hq.size() > 0) h = hq.pop_front();
    else if (int'($urandom_range(99)) < bad_pct) h = ($urandom_range(1) == 1) ? 2'b00 : 2'b11;
    else h = ($urandom_range(1) == 1) ? 2'b01 : 2'b10;
    cur_plain = {$urandom, $urandom};
    for (int i = 0; i < 64; i++) begin
      sc[i] = cur_plain[i] ^ tx_s[38] ^ tx_s[57];
      tx_s  = {tx_s[56:0], sc[i]};
    end
    s_axis_tdata = {sc, h};
  endtask

  // Applies the spec rules to the inputs that were present at the edge just taken.
  task automatic model_edge();
    logic acc, hv;
    acc = s_axis_tvalid && (!ex_v || m_axis_tready);
    hv  = (s_axis_tdata[1:0] == 2'b01) || (s_axis_tdata[1:0] == 2'b10);
    if (acc && ph == P_LOCK) begin
      ex_v = 1'b1;
      ex_t = s_axis_tdata[1:0];
      ex_d = cur_plain;
    end else if (m_axis_tready) begin
      ex_v = 1'b0;
    end
    if (ph == P_SLIP) begin
      if (cyc == slip_start + SLIP_WAIT) begin
        ph   = P_HUNT;
        good = 0;
      end
    end else if (acc && ph == P_HUNT) begin
      if (!hv) begin
        ph         = P_SLIP;
        slip_start = cyc + 1;
      end else begin
        good++;
        if (good == LOCK_CNT) begin
          ph  = P_LOCK;
          win = 0;
          bad = 0;
        end
      end
    end else if (acc) begin
      win++;
      if (!hv) begin
        bad++;
        err++;
      end
      if (bad == INVALID_MAX) begin
        ph         = P_SLIP;
        slip_start = cyc + 1;
      end else if (win == LOCK_CNT) begin
        win = 0;
        bad = 0;
      end
    end
    last_acc = acc;
    cyc++;
  endtask

  task automatic drive_next();
    if (last_acc) gen_block();
    s_axis_tvalid = (int'($urandom_range(99)) < valid_pct);
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = (int'($urandom_range(99)) >= 30);
      default: m_axis_tready = 1'b0;
    endcase
  endtask

  task automatic check_all();
    chk("block_lock", lock, ph == P_LOCK);
    chk("slip", slp, ph == P_SLIP && cyc == slip_start);
    chk("s_tready", s_rdy, !ex_v || m_axis_tready);
    chk("m_tvalid", m_vld, ex_v);
    if (ex_v) begin
      chk("m_ttype", m_typ, ex_t);
      chk("m_tdata", m_dat, ex_d);
      chk("e4_m_ttype", e4_m_typ, ex_t);
      chk("e4_m_tdata", e4_m_dat, ex_d);
    end
    chk("sh_err_cnt", err_cnt, (err > 65535) ? 65535 : err);
    chk("e4_sh_err_cnt", e4_err, (err > 15) ? 15 : err);
    chk("e4_block_lock", e4_lock, ph == P_LOCK);
    chk("e4_slip", e4_slp, ph == P_SLIP && cyc == slip_start);
    chk("e4_s_tready", e4_s_rdy, !ex_v || m_axis_tready);
    chk("e4_m_tvalid", e4_m_vld, ex_v);
    if (slp === 1'b1) slip_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive_next();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    model_reset();
    chk("rst_m_tvalid", m_vld, 1'b0);
    chk("rst_m_ttype", m_typ, 2'b00);
    chk("rst_m_tdata", m_dat, 64'd0);
    chk("rst_block_lock", lock, 1'b0);
    chk("rst_slip", slp, 1'b0);
    chk("rst_sh_err_cnt", err_cnt, 16'd0);
    chk("rst_s_tready", s_rdy, 1'b1);
    chk("rst_e4_m_tvalid", e4_m_vld, 1'b0);
    chk("rst_e4_block_lock", e4_lock, 1'b0);
    chk("rst_e4_sh_err_cnt", e4_err, 4'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_locked(input string tag);
    int n;
    n = 0;
    while (ph != P_LOCK && n < 3000) begin
      step();
      n++;
    end
    chk(tag, lock, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (hq.size() > 0 && n < 3000) begin
      step();
      n++;
    end
    chk(tag, hq.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    valid_pct = 100;
    rdy_mode  = 0;
    bad_pct   = 0;
    slip_seen = 0;
    cyc       = 0;
    model_reset();
    gen_block();

    // Reset values, then lock on a clean stream.
    #2;
    do_reset();
    run_until_locked("t1_lock");
    repeat (4) step();

    // Invalid header at block 10 while hunting: one slip pulse, wait, fresh hunt.
    do_reset();
    slip_seen = 0;
    repeat (8) hq.push_back(2'b01);
    hq.push_back(2'b11);
    run_until_locked("t2_relock");
    chk("t2_slip_pulses", slip_seen, 1);

    // 15 invalids per window for 3 windows keeps lock (first window shifted by the held block).
    repeat (15) hq.push_back(2'b00);
    repeat (48) hq.push_back(2'b01);
    repeat (2) begin
      repeat (15) hq.push_back(2'b00);
      repeat (49) hq.push_back(2'b10);
    end
    drain("t3_drain_a");
    chk("t3_err45", err_cnt, 16'd45);
    chk("t3_still_locked", lock, 1'b1);

    // 16 invalids inside one window: lock lost, all 16 forwarded.
    slip_seen = 0;
    repeat (16) hq.push_back(2'b00);
    drain("t3_drain_b");
    chk("t3_err61", err_cnt, 16'd61);
    chk("t3_lock_lost", lock, 1'b0);
    chk("t6_err_saturated", e4_err, 4'd15);
    run_until_locked("t3_relock");
    chk("t3_slip_pulses", slip_seen, 1);

    // Backpressure: toggling ready, then random ready with sparse bad headers.
    valid_pct = 80;
    rdy_mode  = 1;
    repeat (200) step();
    rdy_mode  = 2;
    bad_pct   = 3;
    repeat (400) step();

    // Reset with a full output register.
    bad_pct   = 0;
    rdy_mode  = 0;
    valid_pct = 100;
    run_until_locked("t6_lock_before_reset");
    rdy_mode = 3;
    repeat (3) step();
    chk("t6_reg_full", m_vld, 1'b1);
    #2;
    do_reset();
    rdy_mode = 0;
    run_until_locked("t6_lock_after_reset");
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder64b66b_lock.md
Name: decoder64b66b_lock

Overview:
Parametrised successor to the 64b/66b decoder. It adds receive block lock, with a sync-header hunt FSM and a bit-slip request to the upstream gearbox. It also adds an optional self-synchronous descrambler (x^58+x^39+1) and a sync-header error counter. It sits between the RX gearbox (66-bit AXI-Stream) and the PCS/MAC receive path (2-bit type plus 64-bit payload).

Parameters:
DESCRAMBLE, 1, 1 = descramble payload; 0 = payload passed through unchanged
LOCK_CNT, 64, consecutive valid headers needed to lock; also the window length while locked
INVALID_MAX, 16, invalid headers within one LOCK_CNT window that cause loss of lock
SLIP_WAIT, 32, clock cycles to wait after a slip pulse before hunting resumes (>=1)
ERR_W, 16, width of the saturating error counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_axis_tdata  in  66  [1:0] = sync header (first bits on wire), [65:2] = scrambled payload
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_ttype  out  2  sync header: 2'b01 data, 2'b10 control, 2'b00/2'b11 illegal
m_axis_tdata  out  64  payload, descrambled when DESCRAMBLE=1
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
block_lock  out  1  high while FSM is in LOCKED
slip  out  1  one-cycle pulse requesting a 1-bit slip from the gearbox
sh_err_cnt  out  ERR_W  invalid headers seen while locked, saturating

Behaviour:
- Reset values: all outputs 0 except s_axis_tready = 1; FSM = HUNT; counters 0; descrambler state 58'b0.
- Accept: an input block is accepted when s_axis_tvalid & s_axis_tready.
- Output stage: single register; s_axis_tready = !m_axis_tvalid | m_axis_tready.
  - Latency is 1 clk from acceptance to m_axis_tvalid.
  - Output holds stable while tvalid & !tready.
- Header valid means header is 2'b01 or 2'b10.
- Descrambler:
  - Advances on every accepted block in all FSM states.
  - Processes bits 0..63 of the payload in order, per bit: out = in ^ S[38] ^ S[57]; S = {S[56:0], in}.
  - With DESCRAMBLE=0, out = in and S is unused.
- Forwarding:
  - Accepted blocks are written to the output register only when the FSM is in LOCKED at acceptance.
  - This includes blocks with illegal headers; ttype is passed raw.
  - Otherwise the block is dropped and tready stays governed by the same equation.
- FSM (transitions evaluated on accepted blocks, except in SLIP):
  - HUNT:
    - Invalid header -> SLIP.
    - Valid header -> sh_cnt++.
    - sh_cnt reaching LOCK_CNT -> LOCKED, counters cleared.
    - The block that completes the count is not forwarded; the next block is.
  - LOCKED:
    - sh_cnt++ per block; sh_inv++ per invalid header.
    - sh_inv reaching INVALID_MAX -> SLIP, block_lock drops the next cycle.
    - sh_cnt reaching LOCK_CNT with sh_inv < INVALID_MAX -> both cleared, stay LOCKED.
    - If both conditions occur on the same block, loss of lock wins.
  - SLIP:
    - slip = 1 for exactly the first cycle in SLIP.
    - Then wait SLIP_WAIT cycles, counted on clk, not on blocks.
    - Input is accepted and dropped during the wait.
    - Then -> HUNT with counters cleared.
- Output on lock loss: a block already in the output register when lock is lost is still delivered.
- sh_err_cnt: increments on each invalid header accepted in LOCKED; saturates at all-ones; cleared only by reset.
- Reset mid-operation: immediate return to reset values; a pending output beat is discarded.
- Counters sh_cnt and sh_inv are sized as $clog2(LOCK_CNT+1).

Decomposition:
- Package dec64b66b_pkg holds:
  - SH_DATA = 2'b01, SH_CTRL = 2'b10
  - state enum {HUNT, LOCKED, SLIP}
  - scrambler tap constants 38 and 57
  - descramble function (64-bit in, 58-bit state -> 64-bit out plus new state)
- One sub-module: descrambler58, combinational next-state/data with a registered state and an enable input. It is instantiated under generate when DESCRAMBLE=1.

Test Plan:
1. Lock: reset, then 64 blocks with header 01 and payload 0 (scrambler state 0) -> block_lock=1 after the 64th accept; block 65 appears on m_axis with ttype 01, tdata 0, sh_err_cnt 0.
2. Hunt slip: an invalid header 11 at block 10 while hunting -> slip pulse of 1 clk; block_lock stays 0 for 32 clk plus a fresh 64 valid blocks, then rises.
3. Loss of lock: while locked, 16 headers 00 within a 64-block window -> all 16 forwarded with ttype 00; sh_err_cnt = 16; block_lock falls; slip pulses once. 15 invalids per window repeated 3 windows -> lock retained, sh_err_cnt = 45.
4. Descrambler: feed 200 payloads produced by a reference x^58+x^39+1 scrambler seeded 58'h3FF_FFFF_FFFF_FFFF, with the descrambler starting at 0 -> every forwarded block after lock equals the original plaintext (self-sync within the first block).
5. Backpressure: locked, m_axis_tready toggled 1010 / random 30% -> no loss or duplication; output stable while stalled; s_axis_tready low only when the register is full and m_axis_tready=0.
6. Saturation/reset: ERR_W=4, 20 invalid headers while locked -> sh_err_cnt = 15. Assert reset mid-stream -> tvalid=0, block_lock=0, FSM back to HUNT.
